// File: rtl/led_pkg.sv
// led_pkg
//   Shared types and default constants for the LED blink bank.
//   mode_t : per-channel operating mode (OFF / ON / BLINK / one-shot PULSE).
//   *_DEF  : default parameter values used by led_blink_bank and led_channel.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_t;

    localparam int NCH_DEF      = 4;
    localparam int TICK_DIV_DEF = 27_000;
    localparam int PER_W_DEF    = 12;
    localparam int PWM_W_DEF    = 8;

endpackage

// File: rtl/led_channel.sv
// led_channel
//   One LED channel: holds mode, period, tick counter and phase, resolves a
//   config write against a base tick arriving in the same cycle (write wins,
//   that tick is dropped for this channel), and presents the next-cycle raw
//   level so the top can register led_o without an extra cycle of latency.
//   Optional feature macro: LED_PWM_EN (adds the per-channel duty register).
// Ports
//   fpga_CLK_AUX  in   clock
//   n_rst         in   async active-low reset
//   wr_en         in   write strobe for this channel (already decoded)
//   tick          in   base tick from the shared prescaler
//   wr_mode       in   mode to load
//   wr_period     in   period to load, 0 is stored as 1
//   wr_duty       in   duty to load (LED_PWM_EN only)
//   raw_nxt       out  raw LED level this channel will have after the edge
//   duty_nxt      out  duty value after the edge (LED_PWM_EN only)
//   busy          out  PULSE in progress (registered)
//
// state      | meaning
// MODE_OFF   | LED dark, counter held at 0
// MODE_ON    | LED lit, counter held at 0
// MODE_BLINK | phase toggles every period ticks
// MODE_PULSE | phase high for period ticks, then back to MODE_OFF
module led_channel
    import led_pkg::*;
#(
    parameter int PER_W = PER_W_DEF,
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             fpga_CLK_AUX,
    input  logic             n_rst,
    input  logic             wr_en,
    input  logic             tick,
    input  mode_t            wr_mode,
    input  logic [PER_W-1:0] wr_period,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] wr_duty,
    output logic [PWM_W-1:0] duty_nxt,
`endif
    output logic             raw_nxt,
    output logic             busy
);

    mode_t            mode_q,   mode_n;
    logic [PER_W-1:0] period_q, period_n;
    logic [PER_W-1:0] cnt_q,    cnt_n;
    logic             phase_q,  phase_n;
    logic             busy_q,   busy_n;
    logic             at_end;

    // cnt never passes period-1, so an equality compare is sufficient.
    assign at_end = (cnt_q == (period_q - PER_W'(1)));

    always_comb begin
        mode_n   = mode_q;
        period_n = period_q;
        cnt_n    = cnt_q;
        phase_n  = phase_q;
        busy_n   = busy_q;
        if (wr_en) begin
            mode_n   = wr_mode;
            period_n = (wr_period == '0) ? PER_W'(1) : wr_period;
            cnt_n    = '0;
            phase_n  = (wr_mode == MODE_BLINK) || (wr_mode == MODE_PULSE);
            busy_n   = (wr_mode == MODE_PULSE);
        end else if (tick) begin
            case (mode_q)
                MODE_OFF, MODE_ON: cnt_n = '0;
                MODE_BLINK: begin
                    if (at_end) begin
                        cnt_n   = '0;
                        phase_n = ~phase_q;
                    end else begin
                        cnt_n = cnt_q + PER_W'(1);
                    end
                end
                MODE_PULSE: begin
                    if (at_end) begin
                        mode_n  = MODE_OFF;
                        cnt_n   = '0;
                        phase_n = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_q + PER_W'(1);
                    end
                end
                default: cnt_n = '0;
            endcase
        end
    end

    always_comb begin
        raw_nxt = 1'b0;
        case (mode_n)
            MODE_OFF: raw_nxt = 1'b0;
            MODE_ON:  raw_nxt = 1'b1;
            default:  raw_nxt = phase_n;
        endcase
    end

    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) begin
            mode_q   <= MODE_OFF;
            period_q <= PER_W'(1);
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mode_q   <= mode_n;
            period_q <= period_n;
            cnt_q    <= cnt_n;
            phase_q  <= phase_n;
            busy_q   <= busy_n;
        end
    end

    assign busy = busy_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] duty_q;

    assign duty_nxt = wr_en ? wr_duty : duty_q;

    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) duty_q <= '1;
        else        duty_q <= duty_nxt;
    end
`endif

endmodule

// File: rtl/led_blink_bank.sv
// led_blink_bank
//   Bank of NCH LED drivers sharing one base-tick prescaler. Each channel is
//   OFF / ON / BLINK / one-shot PULSE with a period in base ticks, written
//   through a single-cycle config port.
//   Optional feature macro: LED_PWM_EN -- adds a free-running PWM counter and
//   per-channel duty so each lit LED is dimmed to duty/2^PWM_W (all-ones duty
//   means constantly on).
// Ports
//   fpga_CLK_AUX  in   clock
//   n_rst         in   async active-low reset
//   cfg_we        in   config write strobe (one cycle)
//   cfg_ch        in   target channel
//   cfg_mode      in   mode to load
//   cfg_period    in   BLINK half-period / PULSE length in ticks (0 -> 1)
//   cfg_duty      in   brightness (LED_PWM_EN only)
//   tick_o        out  base tick, one cycle every TICK_DIV cycles
//   led_o         out  registered LED drives
//   busy_o        out  PULSE in progress per channel
//   cfg_err_o     out  one-cycle pulse after a write to a nonexistent channel
module led_blink_bank
    import led_pkg::*;
#(
    parameter  int NCH      = NCH_DEF,
    parameter  int TICK_DIV = TICK_DIV_DEF,
    parameter  int PER_W    = PER_W_DEF,
    parameter  int PWM_W    = PWM_W_DEF,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             fpga_CLK_AUX,
    input  logic             n_rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  mode_t            cfg_mode,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PWM_W-1:0] cfg_duty,
    output logic             tick_o,
    output logic [NCH-1:0]   led_o,
    output logic [NCH-1:0]   busy_o,
    output logic             cfg_err_o
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick_q;
    logic             ch_valid;
    logic             err_q;
    logic [NCH-1:0]   raw_nxt;
    logic [NCH-1:0]   led_nxt;
    logic [NCH-1:0]   led_q;

    // Prescaler free-runs; config traffic never stalls it.
    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (pre_cnt == PRE_W'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
            tick_q  <= 1'b0;
        end
    end

    // Extra bit so the range check stays meaningful when NCH is a power of two.
    assign ch_valid = ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));

    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) err_q <= 1'b0;
        else        err_q <= cfg_we && !ch_valid;
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
`else
    // Duty only matters in the PWM build.
    logic unused_duty;
    assign unused_duty = ^cfg_duty;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_we;

        assign ch_we = cfg_we && ch_valid && (cfg_ch == CH_W'(i));

`ifdef LED_PWM_EN
        logic [PWM_W-1:0] duty_nxt;

        led_channel #(
            .PER_W (PER_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .fpga_CLK_AUX (fpga_CLK_AUX),
            .n_rst        (n_rst),
            .wr_en        (ch_we),
            .tick         (tick_q),
            .wr_mode      (cfg_mode),
            .wr_period    (cfg_period),
            .wr_duty      (cfg_duty),
            .duty_nxt     (duty_nxt),
            .raw_nxt      (raw_nxt[i]),
            .busy         (busy_o[i])
        );

        // All-ones duty is full-on; otherwise high while pwm_cnt < duty.
        assign led_nxt[i] = raw_nxt[i] & ((duty_nxt == '1) | (pwm_cnt < duty_nxt));
`else
        led_channel #(
            .PER_W (PER_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .fpga_CLK_AUX (fpga_CLK_AUX),
            .n_rst        (n_rst),
            .wr_en        (ch_we),
            .tick         (tick_q),
            .wr_mode      (cfg_mode),
            .wr_period    (cfg_period),
            .raw_nxt      (raw_nxt[i]),
            .busy         (busy_o[i])
        );

        assign led_nxt[i] = raw_nxt[i];
`endif
    end

    // Registered from the channels' next-state level so a write shows on
    // led_o in the very next cycle.
    always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
        if (!n_rst) led_q <= '0;
        else        led_q <= led_nxt;
    end

    assign tick_o    = tick_q;
    assign led_o     = led_q;
    assign cfg_err_o = err_q;

endmodule
